// File: rtl/mem_arbiter_if.sv
// Bundle of the IF/MEM requester handshakes and the memory port served by mem_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  if_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  mem_stall;

  logic                  ram_cs;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  ram_ready;

  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_dout, ram_ready,
    output if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_cs, ram_we, ram_addr, ram_din, busy, timeout_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_dout, ram_ready,
    input  if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_cs, ram_we, ram_addr, ram_din, busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between IF and MEM pipeline stages: MEM priority with a
// bounded burst before a waiting IF is forced in, and a watchdog on ram_ready.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_MEM_BURST = 4,
  parameter int TIMEOUT       = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT, RESP} state_t;

  localparam logic [2:0] BURST_MAX = 3'(MAX_MEM_BURST);
  localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner_mem;
  logic [2:0]            r_burst_cnt;
  logic [7:0]            r_wait_cnt;
  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_mem_rdata;
  logic                  r_timeout_err;

  logic                  w_grant_mem;
  logic                  w_grant_if;
  logic                  w_ready;
  logic                  w_abort;
  logic                  w_if_ack;
  logic                  w_mem_ack;
  logic [DATA_WIDTH-1:0] w_capture;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_ready     = 1'b0;
    w_abort     = 1'b0;
    w_if_ack    = 1'b0;
    w_mem_ack   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.mem_req && (!bus.if_req || r_burst_cnt < BURST_MAX)) begin
          w_grant_mem = 1'b1;
          w_next      = MEM_WAIT;
        end else if (bus.if_req) begin
          w_grant_if = 1'b1;
          w_next     = IF_WAIT;
        end
      end
      IF_WAIT, MEM_WAIT: begin
        if (bus.ram_ready) begin
          w_ready = 1'b1;
          w_next  = RESP;
        end else if (r_wait_cnt == WAIT_MAX) begin
          w_abort = 1'b1;
          w_next  = RESP;
        end
      end
      RESP: begin
        w_if_ack  = !r_owner_mem;
        w_mem_ack = r_owner_mem;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // An aborted load/fetch returns zero rather than whatever the bus holds.
  assign w_capture = w_ready ? bus.ram_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_mem   <= 1'b0;
      r_burst_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_ram_cs      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_if_rdata    <= '0;
      r_mem_rdata   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_grant_mem) begin
        r_ram_cs    <= 1'b1;
        r_ram_we    <= bus.mem_we;
        r_ram_addr  <= bus.mem_addr;
        r_ram_din   <= bus.mem_wdata;
        r_owner_mem <= 1'b1;
        if (!bus.if_req)                r_burst_cnt <= '0;
        else if (r_burst_cnt < BURST_MAX) r_burst_cnt <= r_burst_cnt + 3'd1;
      end else if (w_grant_if) begin
        r_ram_cs    <= 1'b1;
        r_ram_we    <= 1'b0;
        r_ram_addr  <= bus.if_addr;
        r_owner_mem <= 1'b0;
        r_burst_cnt <= '0;
      end

      if (r_state == IF_WAIT || r_state == MEM_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
      else if (r_state == RESP)                      r_wait_cnt <= '0;

      if (w_ready || w_abort) begin
        r_ram_cs <= 1'b0;
        if (!r_ram_we) begin
          if (r_owner_mem) r_mem_rdata <= w_capture;
          else             r_if_rdata  <= w_capture;
        end
        if (w_abort) r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.if_rdata    = r_if_rdata;
  assign bus.if_ack      = w_if_ack;
  assign bus.if_stall    = bus.if_req & ~w_if_ack;
  assign bus.mem_rdata   = r_mem_rdata;
  assign bus.mem_ack     = w_mem_ack;
  assign bus.mem_stall   = bus.mem_req & ~w_mem_ack;
  assign bus.ram_cs      = r_ram_cs;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_din     = r_ram_din;
  assign bus.busy        = (r_state != IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a variable-latency memory responder, a table of
// directed accesses, randomized accesses against a memory model, and corner-case sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 255;
  localparam int HANG = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_MEM_BURST(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int ram_wait_target = 0;
  int ram_cnt = 0;
  bit spurious = 1'b0;

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] g_if_rdata  = '0;
  logic [31:0] g_mem_rdata = '0;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nwait;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  // Contents of never-written memory locations.
  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory device: answers after ram_wait_target non-ready cycles of ram_cs.
  always @(negedge clk) begin
    if (bus.ram_cs) begin
      if (ram_cnt == ram_wait_target) begin
        bus.ram_ready = 1'b1;
        bus.ram_dout  = dev_mem.exists(bus.ram_addr) ? dev_mem[bus.ram_addr] : pattern(bus.ram_addr);
        if (bus.ram_we) dev_mem[bus.ram_addr] = bus.ram_din;
        ram_cnt = 0;
      end else begin
        bus.ram_ready = 1'b0;
        bus.ram_dout  = 32'hBAD0_BAD0;
        ram_cnt++;
      end
    end else begin
      bus.ram_ready = spurious;
      bus.ram_dout  = 32'hBAD0_BAD0;
      ram_cnt       = 0;
    end
  end

  task automatic check_reset();
    check("rst_ram_cs",      32'(bus.ram_cs),      32'd0);
    check("rst_ram_we",      32'(bus.ram_we),      32'd0);
    check("rst_ram_addr",    bus.ram_addr,         32'd0);
    check("rst_ram_din",     bus.ram_din,          32'd0);
    check("rst_if_rdata",    bus.if_rdata,         32'd0);
    check("rst_mem_rdata",   bus.mem_rdata,        32'd0);
    check("rst_acks",        {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
  endtask

  // One isolated access issued from IDLE; called and returns on a falling edge.
  task automatic do_access(input logic is_mem, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int nwait,
                           input logic [31:0] exp_rdata, input int exp_lat);
    int k = 0;
    int cs_cycles = 0;
    bit acked = 1'b0;
    bit bad_bus = 1'b0;
    bit bad_other = 1'b0;
    logic store;
    store = is_mem & we;
    ram_wait_target = nwait;
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr; bus.mem_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    while (!acked && k < 400) begin
      @(negedge clk);
      k++;
      if (bus.ram_cs) begin
        cs_cycles++;
        if (bus.ram_addr !== addr || bus.ram_we !== store || (store && bus.ram_din !== wdata))
          bad_bus = 1'b1;
      end
      if (is_mem ? bus.if_ack : bus.mem_ack) bad_other = 1'b1;
      if (k == 1) check("stall_while_wait", 32'(is_mem ? bus.mem_stall : bus.if_stall), 32'd1);
      if (is_mem ? bus.mem_ack : bus.if_ack) begin
        acked = 1'b1;
        check("stall_in_ack", 32'(is_mem ? bus.mem_stall : bus.if_stall), 32'd0);
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    if (store) ref_mem[addr] = wdata;
    if (is_mem) g_mem_rdata = exp_rdata;
    else        g_if_rdata  = exp_rdata;
    check("ack_latency", k, exp_lat);
    check("ram_cs_cycles", cs_cycles, exp_lat - 1);
    check("ram_bus_fields", 32'(bad_bus), 32'd0);
    check("no_foreign_ack", 32'(bad_other), 32'd0);
    check("owner_rdata", is_mem ? bus.mem_rdata : bus.if_rdata, exp_rdata);
    check("other_rdata", is_mem ? bus.if_rdata : bus.mem_rdata, is_mem ? g_if_rdata : g_mem_rdata);
    @(negedge clk);
    check("ack_one_pulse", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
    check("idle_after", 32'(bus.busy), 32'd0);
  endtask

  // Both requesters held high: model counts MEM grants taken while IF waits.
  task automatic starvation_seq();
    int burst = 0;
    int n_ack = 0;
    int cyc = 0;
    bit both = 1'b0;
    logic exp_owner_mem;
    ram_wait_target = 0;
    bus.if_req = 1'b1;  bus.if_addr = 32'h80;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h90;
    while (n_ack < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.if_ack && bus.mem_ack) both = 1'b1;
      if (bus.if_ack || bus.mem_ack) begin
        exp_owner_mem = (burst < 4);
        burst = exp_owner_mem ? burst + 1 : 0;
        check($sformatf("arb_order_%0d", n_ack), 32'(bus.mem_ack), 32'(exp_owner_mem));
        n_ack++;
      end
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    check("arb_ack_count", n_ack, 10);
    check("arb_dual_ack", 32'(both), 32'd0);
    g_if_rdata  = ref_read(32'h80);
    g_mem_rdata = ref_read(32'h90);
    check("arb_if_rdata", bus.if_rdata, g_if_rdata);
    check("arb_mem_rdata", bus.mem_rdata, g_mem_rdata);
    @(negedge clk);
  endtask

  initial begin
    logic        r_is_mem;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    int          r_nwait;
    int          n_ack;
    int          n_cs;
    bit          bad;

    vecs[0] = '{1'b0, 1'b0, 32'h4,   32'h0,        0, 32'h2008_0005, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 32'h0,         5};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        1, 32'hDEAD_BEEF, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h100, 32'h0,        2, 32'hDEAD_BEEF, 4};
    vecs[4] = '{1'b1, 1'b1, 32'h200, 32'h1234_5678, 0, 32'hDEAD_BEEF, 2};
    vecs[5] = '{1'b0, 1'b0, 32'h8,   32'h0,        4, 32'h8C09_0000, 6};
    vecs[6] = '{1'b1, 1'b0, 32'h200, 32'h0,        5, 32'h1234_5678, 7};

    dev_mem[32'h4] = 32'h2008_0005; ref_mem[32'h4] = 32'h2008_0005;
    dev_mem[32'h8] = 32'h8C09_0000; ref_mem[32'h8] = 32'h8C09_0000;

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_access(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].nwait, vecs[i].exp_rdata, vecs[i].exp_lat);

    starvation_seq();

    spurious = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r_is_mem = 1'($urandom_range(0, 1));
      r_we     = r_is_mem && ($urandom_range(0, 2) == 0);
      r_addr   = 32'h40 + 32'($urandom_range(0, 7)) * 4;
      r_wdata  = $urandom;
      r_nwait  = $urandom_range(0, 6);
      do_access(r_is_mem, r_we, r_addr, r_wdata, r_nwait,
                r_we ? g_mem_rdata : ref_read(r_addr), r_nwait + 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    spurious = 1'b0;

    // IF request withdrawn while its access is in flight.
    ram_wait_target = 3;
    bus.if_req = 1'b1; bus.if_addr = 32'h60;
    n_ack = 0; n_cs = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.if_req = 1'b0;
      if (bus.if_ack) n_ack++;
      if (bus.ram_cs) n_cs++;
    end
    g_if_rdata = ref_read(32'h60);
    check("drop_ack_count", n_ack, 1);
    check("drop_cs_cycles", n_cs, 4);
    check("drop_if_rdata", bus.if_rdata, g_if_rdata);

    check("timeout_err_before", 32'(bus.timeout_err), 32'd0);
    do_access(1'b1, 1'b0, 32'h300, 32'h0, HANG, 32'h0, TO + 2);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    do_access(1'b0, 1'b0, 32'h44, 32'h0, 1, ref_read(32'h44), 3);
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset asserted while a MEM load waits on the memory.
    ram_wait_target = HANG;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h304;
    repeat (5) @(negedge clk);
    check("pre_reset_cs", 32'(bus.ram_cs), 32'd1);
    rst = 1'b1;
    #1;
    check_reset();
    bus.mem_req = 1'b0;
    g_if_rdata = '0; g_mem_rdata = '0;
    bad = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ram_wait_target = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.mem_ack || bus.ram_cs) bad = 1'b1;
    end
    check("no_ack_after_reset", 32'(bad), 32'd0);
    do_access(1'b0, 1'b0, 32'h4, 32'h0, 0, 32'h2008_0005, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage pipelined MIPS CPU. It also generates the per-stage stall signals that the pipeline controller consumes. The memory has variable latency and is driven through a request/ready handshake. MEM has priority, with a bounded-burst anti-starvation rule for IF, and a watchdog aborts hung accesses.

## Interface
- ADDR_WIDTH, 32, byte address width of all address buses
- DATA_WIDTH, 32, data word width
- MAX_MEM_BURST, 4, consecutive MEM grants allowed while IF is waiting before IF is forced in
- TIMEOUT, 255, wait cycles allowed for ram_ready before the access is aborted (8-bit counter)

- clk  in  1  main clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF fetch request, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_rdata  out  DATA_WIDTH  fetched word, valid with if_ack, held until next IF completion
- if_ack  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_ack
- mem_req  in  1  MEM-stage access request, held until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  DATA_WIDTH  store data
- mem_rdata  out  DATA_WIDTH  load data, valid with mem_ack, held until next MEM completion
- mem_ack  out  1  one-cycle completion pulse for MEM
- mem_stall  out  1  mem_req & ~mem_ack
- ram_cs  out  1  memory access strobe, registered
- ram_we  out  1  memory write enable, registered
- ram_addr  out  ADDR_WIDTH  registered access address
- ram_din  out  DATA_WIDTH  registered write data
- ram_dout  in  DATA_WIDTH  memory read data, valid when ram_ready=1
- ram_ready  in  1  memory completion, sampled only while ram_cs=1
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky abort flag, cleared only by rst

## Operation
- The FSM has four states: IDLE, IF_WAIT, MEM_WAIT, RESP.
- IDLE, grant decision (evaluated each cycle):
  - mem_req=1 and (if_req=0 or burst_cnt<MAX_MEM_BURST): grant MEM and go to MEM_WAIT.
  - else if if_req=1: grant IF and go to IF_WAIT.
  - else stay in IDLE.
- On a grant, latch the address, we, wdata and owner into ram_* registers. An IF grant forces ram_we=0.
- burst_cnt (3 bits):
  - Increments on a MEM grant when if_req=1.
  - Clears on any IF grant.
  - Clears on a MEM grant when if_req=0.
  - Saturates at MAX_MEM_BURST.
- IF_WAIT / MEM_WAIT:
  - ram_cs=1, and wait_cnt increments every cycle.
  - On ram_ready=1: capture ram_dout into the owner's rdata register (loads and fetches only; a store leaves mem_rdata unchanged). Drop ram_cs and go to RESP.
  - On wait_cnt==TIMEOUT with ram_ready=0: abort. Drop ram_cs, write 0 into the owner's rdata (not for stores), set timeout_err, and go to RESP.
- RESP:
  - Pulse the owner's ack for exactly one cycle, with no new grant in this cycle.
  - Clear wait_cnt and return to IDLE.
  - The requester must drop req in the ack cycle or present a new request.
- A requester never sees its ack while the other requester is owner. Both acks are never high in the same cycle.
- Requests that change or drop mid-access are ignored; the latched request completes.

## Timing
- Reset values (asynchronous, immediate):
  - FSM state=IDLE; ram_cs=0, ram_we=0.
  - ram_addr, ram_din, if_rdata, mem_rdata = 0.
  - if_ack=0, mem_ack=0, busy=0, timeout_err=0.
  - burst_cnt=0, wait_cnt=0.
- Reset mid-access drops ram_cs in the same cycle. No ack is issued for the aborted access.
- Minimum latency: req seen in IDLE at cycle t, ram_cs=1 at t+1, ram_ready=1 at t+1, ack at t+2. One access per 3 cycles at best.
- A memory with N wait cycles gives ack at t+2+N.
- if_stall and mem_stall are combinational from req/ack and fall in the ack cycle.
- The timeout path aborts in the cycle where wait_cnt reaches TIMEOUT (the TIMEOUT+1-th wait cycle). Ack follows 1 cycle later.
- ram_ready while ram_cs=0 has no effect.

## Test plan
- Single fetch, zero-wait: if_req=1 with if_addr=0x00000004 at t, ram_ready=1 when ram_cs=1, ram_dout=0x20080005 -> ram_cs=1 with ram_addr=0x4 and ram_we=0 at t+1; if_ack=1 and if_rdata=0x20080005 at t+2; if_stall=0 at t+2.
- Store with 3 wait cycles: mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF -> ram_we=1 and ram_din=0xDEADBEEF for 4 cycles; mem_ack at t+5; mem_rdata unchanged.
- Simultaneous requests, priority and starvation: if_req and mem_req both held high, memory zero-wait -> MEM granted 4 times in a row, then IF granted on the 5th arbitration; burst_cnt=0 afterwards.
- Timeout: MEM load with ram_ready held 0 -> ram_cs high for 256 cycles, then drops; mem_ack=1 with mem_rdata=0 one cycle later; timeout_err=1 and stays 1 through later successful accesses.
- Reset mid-access: assert rst during MEM_WAIT -> ram_cs=0, busy=0 and all outputs at reset values in the same cycle; no mem_ack; after release, a new if_req completes normally.
- Request drop mid-access: if_req deasserted during IF_WAIT -> the access completes and if_ack pulses once; no second ram_cs follows.
